// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and the CPU-visible register addresses.
package nes_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [ADDR_W-1:0] OAMDATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side snoop and DMA bus-master signals of the OAM DMA block.
interface oam_dma_if;
  import nes_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_rw;
  logic [DATA_W-1:0] cpu_data_i;
  logic [DATA_W-1:0] bus_data_i;
  logic              halt;
  logic              dma_active;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_rw;
  logic [DATA_W-1:0] dma_data_o;

  modport master (
    input  cpu_addr, cpu_rw, cpu_data_i, bus_data_i,
    output halt, dma_active, dma_addr, dma_rw, dma_data_o
  );

  modport slave (
    output cpu_addr, cpu_rw, cpu_data_i, bus_data_i,
    input  halt, dma_active, dma_addr, dma_rw, dma_data_o
  );

endinterface

// File: rtl/oam_dma.sv
// OAM DMA: copies one 256-byte CPU page into PPU OAMDATA, one read and one write per byte.
// Define OAM_DMA_ALIGN_EN to add the parity-driven ALIGN cycle after HALT.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TRIGGER_ADDR = OAMDMA_ADDR,
  parameter logic [ADDR_W-1:0] TARGET_ADDR  = OAMDATA_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  oam_dma_if.master  bus
);

  oam_dma_state_t    state_q, state_d;
  logic [DATA_W-1:0] page_q, page_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              armed_q;
  logic              trigger_c;
  logic              align_c;

  // armed_q blocks a trigger on the first edge after reset release
  assign trigger_c = armed_q && !bus.cpu_rw && (bus.cpu_addr == TRIGGER_ADDR);

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_q <= 1'b0;
    else      parity_q <= ~parity_q;
  end

  assign align_c = parity_q;
`else
  assign align_c = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      armed_q <= 1'b1;
    end
  end

  // Next state and output decode; outputs depend only on registered values
  always_comb begin
    state_d        = state_q;
    page_d         = page_q;
    idx_d          = idx_q;
    data_d         = data_q;
    bus.halt       = 1'b1;
    bus.dma_active = 1'b1;
    bus.dma_addr   = '0;
    bus.dma_rw     = 1'b1;
    bus.dma_data_o = '0;

    case (state_q)
      IDLE: begin
        bus.halt       = 1'b0;
        bus.dma_active = 1'b0;
        if (trigger_c) begin
          page_d  = bus.cpu_data_i;
          idx_d   = '0;
          state_d = HALT;
        end
      end
      HALT: state_d = align_c ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ: begin
        bus.dma_addr = {page_q, idx_q};
        data_d       = bus.bus_data_i;
        state_d      = WRITE;
      end
      WRITE: begin
        bus.dma_addr   = TARGET_ADDR;
        bus.dma_rw     = 1'b0;
        bus.dma_data_o = data_q;
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: begin
        bus.halt       = 1'b0;
        bus.dma_active = 1'b0;
        state_d        = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma; the bus model returns the low address byte as read data.
module tb_oam_dma;
  import nes_pkg::*;

  logic clk;
  logic rst_n;
  logic par;
  int   total;
  int   bad;

  oam_dma_if bus ();

  oam_dma dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.bus_data_i = bus.dma_addr[7:0];

  // Reference for the CPU cycle parity: toggles every clock, cleared by reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= 1'b0;
    else        par <= ~par;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    bus.cpu_addr   = 16'h0000;
    bus.cpu_rw     = 1'b1;
    bus.cpu_data_i = 8'h00;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_halt"}, 32'(bus.halt), 32'd0);
    check({tag, "_act"},  32'(bus.dma_active), 32'd0);
    check({tag, "_addr"}, 32'(bus.dma_addr), 32'h0000);
    check({tag, "_rw"},   32'(bus.dma_rw), 32'd1);
    check({tag, "_data"}, 32'(bus.dma_data_o), 32'h00);
  endtask

  // Full transfer with the T1 parity chosen by want_par
  task automatic run_dma(input logic [7:0] pg, input bit want_par);
    int n, nr, nw, nother, rerr, werr, aerr, exp_len;
    logic [15:0] first_rd, last_rd, first_wr;
    logic [7:0]  first_wd;
    n = 0; nr = 0; nw = 0; nother = 0; rerr = 0; werr = 0; aerr = 0;
    first_rd = '0; last_rd = '0; first_wr = '0; first_wd = '0;
`ifdef OAM_DMA_ALIGN_EN
    exp_len = want_par ? 514 : 513;
`else
    exp_len = 513;
`endif
    // parity at T1 is the complement of parity at T0
    if (par == want_par) tick();
    bus.cpu_addr   = OAMDMA_ADDR;
    bus.cpu_rw     = 1'b0;
    bus.cpu_data_i = pg;
    check("t0_halt", 32'(bus.halt), 32'd0);
    tick();
    cpu_idle();
    check("t1_halt", 32'(bus.halt), 32'd1);
    check("t1_act", 32'(bus.dma_active), 32'd1);
    while (bus.halt && n < 600) begin
      n++;
      if (!bus.dma_active) aerr++;
      if (bus.dma_rw == 1'b0) begin
        if (nw == 0) begin first_wr = bus.dma_addr; first_wd = bus.dma_data_o; end
        if (bus.dma_addr != OAMDATA_ADDR || bus.dma_data_o != 8'(nw)) werr++;
        nw++;
      end else if (bus.dma_addr != 16'h0000) begin
        if (nr == 0) first_rd = bus.dma_addr;
        last_rd = bus.dma_addr;
        if (bus.dma_addr != {pg, 8'(nr)}) rerr++;
        nr++;
      end else begin
        nother++;
      end
      tick();
    end
    check("halt_len", 32'(n), 32'(exp_len));
    check("pre_cycles", 32'(nother), 32'(exp_len - 512));
    check("n_reads", 32'(nr), 32'd256);
    check("n_writes", 32'(nw), 32'd256);
    check("first_rd", 32'(first_rd), 32'({pg, 8'h00}));
    check("last_rd", 32'(last_rd), 32'({pg, 8'hFF}));
    check("first_wr", 32'(first_wr), 32'h2004);
    check("first_wd", 32'(first_wd), 32'h00);
    check("rd_seq_err", 32'(rerr), 32'd0);
    check("wr_seq_err", 32'(werr), 32'd0);
    check("act_err", 32'(aerr), 32'd0);
    check_idle("post");
  endtask

  initial begin
    bit found;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cpu_idle();
    #1;
    check_idle("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("idle");

    run_dma(8'h02, 1'b0);
    run_dma(8'h02, 1'b1);
    run_dma(8'h07, 1'b0);
    run_dma(8'h20, 1'b1);

    // Non-trigger accesses: read of $4014, write of $4015
    bus.cpu_addr = OAMDMA_ADDR; bus.cpu_rw = 1'b1; bus.cpu_data_i = 8'h02;
    tick();
    bus.cpu_addr = 16'h4015; bus.cpu_rw = 1'b0;
    tick();
    cpu_idle();
    check("nt_halt0", 32'(bus.halt), 32'd0);
    tick();
    check("nt_halt1", 32'(bus.halt), 32'd0);

    // Reset mid-transfer during the READ of idx 8'h40
    bus.cpu_addr = OAMDMA_ADDR; bus.cpu_rw = 1'b0; bus.cpu_data_i = 8'h05;
    tick();
    cpu_idle();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (bus.dma_rw && bus.dma_addr == 16'h0540) found = 1'b1;
      else tick();
    end
    check("rst_reach", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("par_rst", 32'(par), 32'd0);
    tick();
    check_idle("held_rst");
    rst_n = 1'b1;
    tick();
    tick();
    check_idle("after_rst");
    run_dma(8'h03, 1'b0);

    // Trigger in the cycle reset deasserts is ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.cpu_addr = OAMDMA_ADDR; bus.cpu_rw = 1'b0; bus.cpu_data_i = 8'h04;
    tick();
    cpu_idle();
    check("rel_trig_halt0", 32'(bus.halt), 32'd0);
    tick();
    check("rel_trig_halt1", 32'(bus.halt), 32'd0);

    // Transfer after that still works at both parities
    run_dma(8'h04, 1'b1);
    run_dma(8'h04, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
